// File: rtl/auth_err_msg_tx_pkg.sv
// Shared definitions for the authentication responder header path:
// header geometry, fixed header field values and the serializer FSM encoding.
package auth_defs;

    localparam int SIZE_OF_HEADER_VARS     = 8;
    localparam int SIZE_OF_HEADER_IN_BYTES = 4;

    localparam logic [7:0] PROTOCOL_VERSION = 8'h10;
    localparam logic [7:0] ERROR_RESP_CMD   = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/auth_stall_timer.sv
// Saturating stall counter. o_expired flags the enabled cycle whose count
// increment makes the counter reach LIMIT, so the owner can abort on the
// same edge the limit is reached. Clear has priority over enable.
module auth_stall_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW     = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] MAX_C  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST_C = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // Count consecutive enabled cycles, holding at LIMIT instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX_C)) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_en && !i_clr && (r_count >= LAST_C);

endmodule

// File: rtl/auth_err_msg_tx.sv
// Error-response header serializer: captures the header when MSG_ready is
// seen in IDLE and streams it MSB byte first over a valid/ready interface.
// Reports done / stall-timeout / rejected-payload as one-cycle pulses.
module auth_err_msg_tx
    import auth_defs::*;
#(
    parameter int HDR_BYTES   = SIZE_OF_HEADER_IN_BYTES,
    parameter int BYTE_W      = SIZE_OF_HEADER_VARS,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        MSG_ready,
    input  logic [HDR_BYTES*BYTE_W-1:0] header,
    input  logic                        payload,
    output logic [BYTE_W-1:0]           tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        tx_last,
    output logic                        tx_done,
    output logic                        tx_timeout,
    output logic                        tx_error,
    output logic                        busy
);

    localparam int            HW       = HDR_BYTES * BYTE_W;
    localparam int            IW       = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(HDR_BYTES - 1);

    tx_state_t         r_state, w_state;
    logic [HW-1:0]     r_shift, w_shift, w_shifted;
    logic [IW-1:0]     r_idx, w_idx;
    logic [BYTE_W-1:0] r_data, w_data;
    logic              r_valid, w_valid;
    logic              r_last, w_last;
    logic              r_done_pend, w_done_pend;
    logic              r_done, w_done;
    logic              r_timeout, w_timeout;
    logic              r_error, w_error;
    logic              r_busy, w_busy;
    logic              w_hs, w_stall, w_capture, w_clr, w_expired;

    assign w_hs      = (r_state == ST_SEND) && r_valid && tx_ready;
    assign w_stall   = (r_state == ST_SEND) && r_valid && !tx_ready;
    assign w_capture = (r_state == ST_IDLE) && MSG_ready && !payload;
    assign w_clr     = w_capture || w_hs;
    assign w_shifted = r_shift << BYTE_W;

    auth_stall_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_stall_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_en      (w_stall),
        .o_expired (w_expired)
    );

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_idx       = r_idx;
        w_data      = r_data;
        w_valid     = r_valid;
        w_last      = r_last;
        w_done_pend = 1'b0;
        w_timeout   = 1'b0;
        w_error     = 1'b0;
        w_done      = r_done_pend;
        case (r_state)
            ST_IDLE: begin
                if (MSG_ready) begin
                    if (!payload) begin
                        w_state = ST_SEND;
                        w_shift = header;
                        w_idx   = '0;
                        w_data  = header[HW-1 -: BYTE_W];
                        w_valid = 1'b1;
                        w_last  = (HDR_BYTES == 1);
                    end else begin
                        w_state = ST_RELEASE;
                        w_error = 1'b1;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    w_shift = w_shifted;
                    w_idx   = r_idx + IW'(1);
                    if (r_last) begin
                        w_state     = ST_RELEASE;
                        w_valid     = 1'b0;
                        w_last      = 1'b0;
                        w_data      = '0;
                        w_done_pend = 1'b1;
                    end else begin
                        w_data = w_shifted[HW-1 -: BYTE_W];
                        w_last = (w_idx == LAST_IDX);
                    end
                end else if (w_expired) begin
                    // Handshake is checked first, so a final accept on the
                    // limit cycle completes instead of timing out.
                    w_state   = ST_RELEASE;
                    w_valid   = 1'b0;
                    w_last    = 1'b0;
                    w_data    = '0;
                    w_timeout = 1'b1;
                end else begin
                    w_state = ST_SEND;
                end
            end
            ST_RELEASE: begin
                // Wait for the level request to drop so a held MSG_ready
                // cannot trigger a second transmission of the same frame.
                if (!MSG_ready) begin
                    w_state = ST_IDLE;
                end else begin
                    w_state = ST_RELEASE;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_valid = 1'b0;
                w_last  = 1'b0;
                w_data  = '0;
            end
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Datapath and output registers; reset discards any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_shift     <= w_shift;
            r_idx       <= w_idx;
            r_data      <= w_data;
            r_valid     <= w_valid;
            r_last      <= w_last;
            r_done_pend <= w_done_pend;
            r_done      <= w_done;
            r_timeout   <= w_timeout;
            r_error     <= w_error;
            r_busy      <= w_busy;
        end
    end

    assign tx_data    = r_data;
    assign tx_valid   = r_valid;
    assign tx_last    = r_last;
    assign tx_done    = r_done;
    assign tx_timeout = r_timeout;
    assign tx_error   = r_error;
    assign busy       = r_busy;

endmodule

// File: tb/tb_auth_err_msg_tx.sv
// Randomized bench for auth_err_msg_tx. Expected bytes, pulse timing and
// pulse counts are derived from the frame rules (byte k = header bits
// [31-8k -: 8], done one cycle after the final accept, abort after TO
// consecutive stalls) and compared with a byte monitor and directed checks.
module tb_auth_err_msg_tx;
    import auth_defs::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MSG_ready = 1'b0;
    logic        payload = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] header = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last, tx_done, tx_timeout, tx_error, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done = 0, n_to = 0, n_err = 0;
    int exp_done = 0, exp_to = 0, exp_err = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    auth_err_msg_tx #(
        .HDR_BYTES   (4),
        .BYTE_W      (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MSG_ready  (MSG_ready),
        .header     (header),
        .payload    (payload),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .tx_done    (tx_done),
        .tx_timeout (tx_timeout),
        .tx_error   (tx_error),
        .busy       (busy)
    );

    // Mid-cycle monitor: records bytes that the next rising edge accepts and counts pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (tx_done)    n_done++;
            if (tx_timeout) n_to++;
            if (tx_error)   n_err++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] h, input int k);
        return h[(31 - 8 * k) -: 8];
    endfunction

    task automatic compare_bytes(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, tx_valid, 1'b0);
        check_eq({tag, "_data"}, tx_data, 8'h00);
        check_eq({tag, "_last"}, tx_last, 1'b0);
        check_eq({tag, "_done"}, tx_done, 1'b0);
        check_eq({tag, "_timeout"}, tx_timeout, 1'b0);
        check_eq({tag, "_error"}, tx_error, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    // Capture in IDLE and check the first byte appears one edge later
    task automatic capture(input logic [31:0] hdr);
        header    = hdr;
        payload   = 1'b0;
        MSG_ready = 1'b1;
        tx_ready  = 1'($urandom_range(0, 1));
        tick();
        check_eq("cap_valid", tx_valid, 1'b1);
        check_eq("cap_data", tx_data, byte_of(hdr, 0));
        check_eq("cap_last", tx_last, 1'b0);
        check_eq("cap_busy", busy, 1'b1);
    endtask

    // Full frame with st[k] stall cycles before byte k is accepted
    task automatic run_frame(input logic [31:0] hdr, input int st [4]);
        capture(hdr);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < st[k]; s++) begin
                tx_ready  = 1'b0;
                MSG_ready = 1'($urandom_range(0, 1));
                header    = $urandom;
                tick();
                check_eq("stall_valid", tx_valid, 1'b1);
                check_eq("stall_data", tx_data, byte_of(hdr, k));
                check_eq("stall_last", tx_last, (k == 3));
                check_eq("stall_timeout", tx_timeout, 1'b0);
            end
            tx_ready  = 1'b1;
            MSG_ready = 1'($urandom_range(0, 1));
            header    = $urandom;
            exp_q.push_back(byte_of(hdr, k));
            tick();
            if (k < 3) begin
                check_eq("next_valid", tx_valid, 1'b1);
                check_eq("next_data", tx_data, byte_of(hdr, k + 1));
                check_eq("next_last", tx_last, (k + 1 == 3));
            end else begin
                check_eq("end_valid", tx_valid, 1'b0);
                check_eq("end_last", tx_last, 1'b0);
                check_eq("end_done_early", tx_done, 1'b0);
                check_eq("end_busy", busy, 1'b1);
            end
        end
        MSG_ready = 1'b0;
        tx_ready  = 1'($urandom_range(0, 1));
        tick();
        exp_done++;
        check_eq("done_pulse", tx_done, 1'b1);
        check_eq("done_busy", busy, 1'b0);
        tick();
        check_eq("done_clear", tx_done, 1'b0);
        check_eq("post_valid", tx_valid, 1'b0);
        compare_bytes("frame");
    endtask

    // Accept nacc bytes, then hold tx_ready low until the frame aborts
    task automatic run_timeout(input logic [31:0] hdr, input int nacc);
        capture(hdr);
        for (int k = 0; k < nacc; k++) begin
            tx_ready = 1'b1;
            exp_q.push_back(byte_of(hdr, k));
            tick();
            check_eq("to_acc_data", tx_data, byte_of(hdr, k + 1));
        end
        tx_ready = 1'b0;
        for (int s = 1; s <= TO; s++) begin
            tick();
            if (s < TO) begin
                check_eq("to_hold_valid", tx_valid, 1'b1);
                check_eq("to_hold_data", tx_data, byte_of(hdr, nacc));
                check_eq("to_early", tx_timeout, 1'b0);
            end else begin
                check_eq("to_drop_valid", tx_valid, 1'b0);
                check_eq("to_pulse", tx_timeout, 1'b1);
                check_eq("to_busy", busy, 1'b1);
                check_eq("to_no_done", tx_done, 1'b0);
            end
        end
        exp_to++;
        for (int s = 0; s < 4; s++) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick();
            check_eq("to_release_valid", tx_valid, 1'b0);
            check_eq("to_release_busy", busy, 1'b1);
            check_eq("to_single", tx_timeout, 1'b0);
            check_eq("to_no_done2", tx_done, 1'b0);
        end
        MSG_ready = 1'b0;
        tick();
        check_eq("to_idle_busy", busy, 1'b0);
        compare_bytes("timeout");
    endtask

    initial begin
        int st [4];
        logic [31:0] h;

        // Reset state
        #1;
        check_idle_outputs("reset");
        #21;
        rst_n = 1'b1;
        tick();
        check_idle_outputs("after_reset");

        // Basic frame, no stalls
        st = '{0, 0, 0, 0};
        run_frame(32'h10_01_03_00, st);
        // Three stall cycles before byte 2
        st = '{0, 0, 3, 0};
        run_frame(32'h10_01_03_00, st);
        // One short of the abort limit before several bytes
        st = '{TO - 1, 0, TO - 1, TO - 1};
        run_frame($urandom, st);
        // Random frames with random stalls below the limit
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 4; k++) st[k] = $urandom_range(0, TO - 1);
            h = {PROTOCOL_VERSION, ERROR_RESP_CMD, 16'($urandom)};
            if (f[0]) h = $urandom;
            run_frame(h, st);
        end

        // Stall timeout on the first byte and on a random later byte
        run_timeout($urandom, 0);
        run_timeout($urandom, $urandom_range(1, 3));

        // MSG_ready held high: exactly one frame
        h = $urandom;
        header    = h;
        payload   = 1'b0;
        MSG_ready = 1'b1;
        tx_ready  = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(byte_of(h, k));
        repeat (50) tick();
        exp_done++;
        check_eq("held_busy", busy, 1'b1);
        compare_bytes("held");
        check_eq("held_done_count", n_done, exp_done);
        MSG_ready = 1'b0;
        tick();
        check_eq("held_release_busy", busy, 1'b0);
        st = '{0, 1, 0, 2};
        run_frame($urandom, st);

        // Payload present: rejected, nothing sent
        header    = $urandom;
        payload   = 1'b1;
        MSG_ready = 1'b1;
        tx_ready  = 1'b1;
        tick();
        exp_err++;
        check_eq("err_pulse", tx_error, 1'b1);
        check_eq("err_valid", tx_valid, 1'b0);
        check_eq("err_busy", busy, 1'b1);
        for (int s = 0; s < 5; s++) begin
            tick();
            check_eq("err_single", tx_error, 1'b0);
            check_eq("err_no_valid", tx_valid, 1'b0);
            check_eq("err_release_busy", busy, 1'b1);
        end
        MSG_ready = 1'b0;
        payload   = 1'b0;
        tick();
        check_eq("err_idle_busy", busy, 1'b0);
        compare_bytes("err");

        // Asynchronous reset after two bytes
        h = $urandom;
        capture(h);
        tx_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(byte_of(h, k));
            tick();
        end
        tx_ready = 1'b0;
        MSG_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("rst_release");
        compare_bytes("rst");
        st = '{0, 0, 0, 0};
        run_frame($urandom, st);

        // Pulse totals across the whole run
        tick();
        check_eq("total_done", n_done, exp_done);
        check_eq("total_timeout", n_to, exp_to);
        check_eq("total_error", n_err, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
